// File: rtl/ahb_fetch_master_if.sv
// AHB-Lite read-side bus bundle between the fetch master and a slave.
// The master drives address/control; the slave returns ready and read data.
interface ahb_fetch_master_if;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hready;
   logic [31:0] hrdata;

   modport master (
      output haddr, htrans, hburst, hwrite, hsize,
      input  hready, hrdata
   );

   modport slave (
      input  haddr, htrans, hburst, hwrite, hsize,
      output hready, hrdata
   );
endinterface

// File: rtl/ahb_fetch_master.sv
// AHB-Lite line-fetch initiator: turns one request into a SINGLE or WRAP4 read
// and returns each data beat together with its offset inside the 16-byte line.
module ahb_fetch_master #(
   parameter logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0,
   parameter int          BEATS_WRAP4         = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic [2:0]          req_burst,
   ahb_fetch_master_if.master  ahb,
   output logic                rd_valid,
   output logic [31:0]         rd_data,
   output logic [3:0]          rd_offset,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, ADDR, BURST, LAST} state_t;

   localparam logic [2:0] LAST_CNT     = 3'(BEATS_WRAP4 - 1);
   localparam logic [2:0] BURST_SINGLE = 3'b000;
   localparam logic [2:0] BURST_WRAP4  = 3'b010;
   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   state_t      state;
   state_t      state_next;
   logic [31:0] base_addr;
   logic [2:0]  burst_type;
   logic        is_wrap;
   logic [3:0]  addr_off;
   logic [3:0]  data_off;
   logic [2:0]  addr_cnt;
   logic [1:0]  htrans_c;
   logic        accept;
   logic        addr_take;
   logic        sample;

   assign is_wrap    = (burst_type == BURST_WRAP4);
   assign ahb.haddr  = (base_addr & WRAP4_BOUNDARY_MASK) | {28'b0, addr_off};
   assign ahb.htrans = htrans_c;
   assign ahb.hburst = burst_type;
   assign ahb.hwrite = 1'b0;
   assign ahb.hsize  = 3'b010;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = ADDR;
         ADDR:    if (ahb.hready) state_next = is_wrap ? BURST : LAST;
         BURST:   if (ahb.hready && addr_cnt == LAST_CNT) state_next = LAST;
         LAST:    if (ahb.hready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // sample marks an edge that closes a data phase; addr_take one that accepts an address phase
   always_comb begin
      req_ready = 1'b0;
      htrans_c  = TRANS_IDLE;
      accept    = 1'b0;
      addr_take = 1'b0;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
         end
         ADDR: begin
            htrans_c  = TRANS_NONSEQ;
            addr_take = ahb.hready;
         end
         BURST: begin
            htrans_c  = TRANS_SEQ;
            addr_take = ahb.hready;
            sample    = ahb.hready;
         end
         LAST: begin
            sample    = ahb.hready;
         end
         default: ;
      endcase
   end

   // data_off trails addr_off by one accepted address phase, matching the AHB pipeline
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_addr  <= '0;
         burst_type <= BURST_SINGLE;
         addr_off   <= '0;
         data_off   <= '0;
         addr_cnt   <= '0;
      end else if (accept) begin
         base_addr  <= req_addr & 32'hFFFF_FFFC;
         burst_type <= (req_burst == BURST_WRAP4) ? BURST_WRAP4 : BURST_SINGLE;
         addr_off   <= req_addr[3:0] & 4'hC;
         addr_cnt   <= '0;
      end else if (addr_take) begin
         addr_off   <= addr_off + 4'd4;
         data_off   <= addr_off;
         addr_cnt   <= addr_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_offset <= '0;
         done      <= 1'b0;
      end else begin
         rd_valid <= sample;
         done     <= sample && (state == LAST);
         if (sample) begin
            rd_data   <= ahb.hrdata;
            rd_offset <= data_off;
         end
      end
   end

endmodule
